// File: rtl/i2c_mem_arbiter.sv
// i2c_mem_arbiter: round-robin arbiter and transaction sequencer in front of a
// single i2c_mem port. Every launch lines up with the memory's done boundary,
// so wr/addr/din are stable whenever the memory samples them. A watchdog
// aborts any transaction that never completes.
module i2c_mem_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   req_wr_i,
  input  logic [7*N_REQ-1:0] req_addr_i,
  input  logic [8*N_REQ-1:0] req_din_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   ack_o,
  output logic               err_o,
  output logic [7:0]         rdata_o,
  output logic               mem_wr_o,
  output logic [6:0]         mem_addr_o,
  output logic [7:0]         mem_din_o,
  input  logic [7:0]         mem_datard_i,
  input  logic               mem_done_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2
  } state_e;

  state_e             state_q;
  logic [IW-1:0]      ptr_q;
  logic [TW-1:0]      timer_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   ack_q;
  logic               err_q;
  logic [7:0]         rdata_q;
  logic               memWr_q;
  logic [6:0]         memAddr_q;
  logic [7:0]         memDin_q;

  logic [N_REQ-1:0]   ownMask;
  logic [N_REQ-1:0]   candidates;
  logic [N_REQ-1:0]   winOneHot;
  logic               winValid;
  logic [IW-1:0]      winIdx;
  logic               winWr;
  logic [6:0]         winAddr;
  logic [7:0]         winDin;

  // The requester currently owning the port is excluded while BUSY so that
  // nobody is granted twice in a row while someone else is waiting.
  always_comb begin
    ownMask = '0;
    ownMask[ptr_q] = 1'b1;
    candidates = (state_q == BUSY) ? (req_i & ~ownMask) : req_i;
  end

  // Round-robin search starting just after the last winner; the descending
  // loop leaves the nearest set request as the final assignment.
  always_comb begin
    winValid = 1'b0;
    winIdx   = ptr_q;
    for (int k = N_REQ; k >= 1; k--) begin
      if (candidates[(int'(ptr_q) + k) % N_REQ]) begin
        winValid = 1'b1;
        winIdx   = IW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // One-hot form of the winner plus its operation fields.
  always_comb begin
    winOneHot = '0;
    winOneHot[winIdx] = 1'b1;
    winWr   = req_wr_i[winIdx];
    winAddr = req_addr_i[int'(winIdx)*7 +: 7];
    winDin  = req_din_i[int'(winIdx)*8 +: 8];
  end

  // Sequencer: all outputs are registered here, and mem_* only move on a
  // done edge, on a watchdog abort, or in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC;
      ptr_q     <= LAST_IDX;
      timer_q   <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= 8'h00;
      memWr_q   <= 1'b0;
      memAddr_q <= 7'h00;
      memDin_q  <= 8'h00;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      case (state_q)
        SYNC: begin
          if (mem_done_i) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (mem_done_i && winValid) begin
            memWr_q   <= winWr;
            memAddr_q <= winAddr;
            memDin_q  <= winDin;
            gnt_q     <= winOneHot;
            timer_q   <= '0;
            ptr_q     <= winIdx;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (mem_done_i) begin
            ack_q <= ownMask;
            if (!memWr_q) begin
              rdata_q <= mem_datard_i;
            end
            if (winValid) begin
              memWr_q   <= winWr;
              memAddr_q <= winAddr;
              memDin_q  <= winDin;
              gnt_q     <= winOneHot;
              timer_q   <= '0;
              ptr_q     <= winIdx;
            end else begin
              memWr_q   <= 1'b0;
              memAddr_q <= 7'h00;
              memDin_q  <= 8'h00;
              gnt_q     <= '0;
              state_q   <= IDLE;
            end
          end else if (timer_q == TIMER_MAX) begin
            ack_q     <= ownMask;
            err_q     <= 1'b1;
            memWr_q   <= 1'b0;
            memAddr_q <= 7'h00;
            memDin_q  <= 8'h00;
            gnt_q     <= '0;
            state_q   <= SYNC;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= SYNC;
        end
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign ack_o      = ack_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign mem_wr_o   = memWr_q;
  assign mem_addr_o = memAddr_q;
  assign mem_din_o  = memDin_q;

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Testbench for i2c_mem_arbiter: a behavioural i2c_mem stand-in, a scoreboard
// of expected completions, and directed scenarios for ordering, fairness,
// watchdog, reset and boundary addresses.
module tb_i2c_mem_arbiter;

  localparam int N      = 4;
  localparam int TMO    = 64;
  localparam int PERIOD = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_i;
  logic [N-1:0]   req_wr_i;
  logic [7*N-1:0] req_addr_i;
  logic [8*N-1:0] req_din_i;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   ack_o;
  logic           err_o;
  logic [7:0]     rdata_o;
  logic           mem_wr_o;
  logic [6:0]     mem_addr_o;
  logic [7:0]     mem_din_o;
  logic [7:0]     mem_datard_i;
  logic           mem_done_i;

  i2c_mem_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .req_wr_i     (req_wr_i),
    .req_addr_i   (req_addr_i),
    .req_din_i    (req_din_i),
    .gnt_o        (gnt_o),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .rdata_o      (rdata_o),
    .mem_wr_o     (mem_wr_o),
    .mem_addr_o   (mem_addr_o),
    .mem_din_o    (mem_din_o),
    .mem_datard_i (mem_datard_i),
    .mem_done_i   (mem_done_i)
  );

  typedef struct {
    int         idx;
    logic [7:0] rdata;
    logic       err;
    logic [3:0] gntAfter;
  } exp_t;

  exp_t       sb[$];
  int         testsRun = 0;
  int         failCount = 0;
  int         remaining[N];
  int         cycle = 0;
  logic       doneEnable = 1'b1;
  logic [7:0] memArr[128];

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurements.
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [7:0] pat(input logic [6:0] a);
    return {a, 1'b1} ^ 8'h3C;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectAck(input int idx, input logic [7:0] rd, input logic err,
                           input logic [3:0] gntAfter);
    exp_t e;
    e.idx = idx;
    e.rdata = rd;
    e.err = err;
    e.gntAfter = gntAfter;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int idx, input logic wr, input logic [6:0] addr,
                               input logic [7:0] din, input int count);
    req_wr_i[idx] = wr;
    req_addr_i[idx*7 +: 7] = addr;
    req_din_i[idx*8 +: 8] = din;
    remaining[idx] = count;
    req_i[idx] = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt_o), 0);
    checkOutput({tag, "_ack"}, 32'(ack_o), 0);
    checkOutput({tag, "_err"}, 32'(err_o), 0);
    checkOutput({tag, "_rdata"}, 32'(rdata_o), 0);
    checkOutput({tag, "_mem_wr"}, 32'(mem_wr_o), 0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr_o), 0);
    checkOutput({tag, "_mem_din"}, 32'(mem_din_o), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req_i = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && gnt_o == '0 && req_i == '0) return;
    end
    checkOutput({tag, "_idle_timeout"}, {16'(sb.size()), 8'(gnt_o), 8'(req_i)}, 0);
    sb.delete();
  endtask

  task automatic waitGnt(input string tag, input int idx);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (gnt_o[idx]) return;
    end
    checkOutput({tag, "_gnt_timeout"}, 32'(gnt_o), 32'(1) << idx);
  endtask

  // Behavioural i2c_mem: done every PERIOD cycles, samples wr/addr/din two
  // cycles after done, returns read data during the closing done cycle.
  initial begin
    int         cnt;
    logic       curWr;
    logic [6:0] curAddr;
    cnt = 0;
    curWr = 1'b0;
    curAddr = 7'h00;
    mem_done_i = 1'b0;
    mem_datard_i = 8'h00;
    for (int a = 0; a < 128; a++) memArr[a] = pat(7'(a));
    forever begin
      @(negedge clk);
      if (doneEnable && cnt >= PERIOD - 1) begin
        mem_done_i = 1'b1;
        mem_datard_i = curWr ? 8'hEE : memArr[curAddr];
        cnt = 0;
      end else begin
        mem_done_i = 1'b0;
        mem_datard_i = 8'h00;
        cnt++;
        if (cnt == 2) begin
          curWr = mem_wr_o;
          curAddr = mem_addr_o;
          if (curWr) memArr[curAddr] = mem_din_o;
        end
      end
    end
  end

  // Monitor: scoreboard compare on every ack, alignment checks on grant and
  // mem_* changes, and requester release once its acks are used up.
  initial begin
    logic [3:0]  prevGnt;
    logic [15:0] prevMem;
    exp_t        e;
    prevGnt = '0;
    prevMem = '0;
    forever begin
      @(posedge clk); #1;
      if (gnt_o !== prevGnt && gnt_o != '0)
        checkOutput("gnt_on_done", 32'(mem_done_i), 1);
      if ({mem_wr_o, mem_addr_o, mem_din_o} !== prevMem && !rst && !err_o)
        checkOutput("mem_stable", 32'(mem_done_i), 1);
      if (ack_o != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_ack", 32'(ack_o), 0);
        end else begin
          e = sb.pop_front();
          checkOutput("ack_idx", 32'(ack_o), 32'(1) << e.idx);
          checkOutput("ack_err", 32'(err_o), 32'(e.err));
          checkOutput("ack_gnt", 32'(gnt_o), 32'(e.gntAfter));
          checkOutput("ack_rdata", 32'(rdata_o), 32'(e.rdata));
        end
        for (int i = 0; i < N; i++) begin
          if (ack_o[i] && remaining[i] > 0) begin
            remaining[i]--;
            if (remaining[i] == 0) req_i[i] = 1'b0;
          end
        end
      end else if (err_o) begin
        checkOutput("err_without_ack", 32'(err_o), 0);
      end
      prevGnt = gnt_o;
      prevMem = {mem_wr_o, mem_addr_o, mem_din_o};
    end
  end

  // Hard time limit so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Directed scenarios.
  initial begin
    int c0;
    int doneCount;
    rst = 1'b1;
    req_i = '0;
    req_wr_i = '0;
    req_addr_i = '0;
    req_din_i = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("por");
    @(negedge clk);
    rst = 1'b0;

    // Single write then read back by requester 0.
    @(negedge clk);
    expectAck(0, 8'h00, 1'b0, 4'b0000);
    applyStimulus(0, 1'b1, 7'h12, 8'hA5, 1);
    waitIdle("wr_single");
    @(negedge clk);
    expectAck(0, 8'hA5, 1'b0, 4'b0000);
    applyStimulus(0, 1'b0, 7'h12, 8'h00, 1);
    waitIdle("rd_single");

    // Four simultaneous reads after reset: order 0,1,2,3, back to back.
    doReset();
    @(negedge clk);
    expectAck(0, pat(7'h40), 1'b0, 4'b0010);
    expectAck(1, pat(7'h41), 1'b0, 4'b0100);
    expectAck(2, pat(7'h42), 1'b0, 4'b1000);
    expectAck(3, pat(7'h43), 1'b0, 4'b0000);
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, 7'(7'h40 + i), 8'h00, 1);
    waitIdle("all_four");

    // Fairness: requesters 1 and 3 hold req, grants alternate.
    @(negedge clk);
    expectAck(1, pat(7'h21), 1'b0, 4'b1000);
    expectAck(3, pat(7'h33), 1'b0, 4'b0010);
    expectAck(1, pat(7'h21), 1'b0, 4'b1000);
    expectAck(3, pat(7'h33), 1'b0, 4'b0010);
    expectAck(1, pat(7'h21), 1'b0, 4'b1000);
    expectAck(3, pat(7'h33), 1'b0, 4'b0000);
    applyStimulus(1, 1'b0, 7'h21, 8'h00, 3);
    applyStimulus(3, 1'b0, 7'h33, 8'h00, 3);
    waitIdle("fairness");

    // Watchdog: memory stops issuing done after the launch.
    @(negedge clk);
    expectAck(2, pat(7'h33), 1'b1, 4'b0000);
    applyStimulus(2, 1'b0, 7'h50, 8'h00, 1);
    waitGnt("wd", 2);
    c0 = cycle;
    doneEnable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ack_o != '0) break;
    end
    checkOutput("wd_latency", 32'(cycle - c0), 64);
    repeat (3) @(posedge clk);
    @(negedge clk);
    expectAck(0, 8'hA5, 1'b0, 4'b0000);
    applyStimulus(0, 1'b0, 7'h12, 8'h00, 1);
    @(posedge clk); #1;
    doneEnable = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (mem_done_i) doneCount++;
      if (gnt_o != '0) break;
    end
    checkOutput("sync_resume_dones", 32'(doneCount), 2);
    waitIdle("wd_resume");

    // Reset in the middle of a transaction, then a normal write/read.
    @(negedge clk);
    applyStimulus(1, 1'b1, 7'h30, 8'h99, 1);
    waitGnt("midrst", 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_i = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    @(posedge clk); #1;
    checkResetValues("midrst");
    @(negedge clk);
    rst = 1'b0;
    expectAck(0, 8'h00, 1'b0, 4'b0000);
    applyStimulus(0, 1'b1, 7'h7F, 8'h3C, 1);
    waitIdle("post_rst_wr");
    @(negedge clk);
    expectAck(0, 8'h3C, 1'b0, 4'b0000);
    applyStimulus(0, 1'b0, 7'h7F, 8'h00, 1);
    waitIdle("post_rst_rd");

    // Boundary addresses 0x00 and 0x7F.
    @(negedge clk);
    expectAck(2, 8'h3C, 1'b0, 4'b1000);
    expectAck(3, 8'h3C, 1'b0, 4'b0000);
    applyStimulus(2, 1'b1, 7'h00, 8'hFF, 1);
    applyStimulus(3, 1'b1, 7'h7F, 8'h01, 1);
    waitIdle("bound_wr");
    @(negedge clk);
    expectAck(2, 8'hFF, 1'b0, 4'b1000);
    expectAck(3, 8'h01, 1'b0, 4'b0000);
    applyStimulus(2, 1'b0, 7'h00, 8'h00, 1);
    applyStimulus(3, 1'b0, 7'h7F, 8'h00, 1);
    waitIdle("bound_rd");

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
